kbd_arbiter: RTL and testbench

Shares the Apple-1 keyboard input register between two character sources: the UART receiver (host paste/terminal) and the PS/2 scancode decoder.
- Buffers UART bytes in a small FIFO and drives uart_cts flow control so bulk pastes are not lost at 6502 speed.
- Round-robin arbitrates between the sources when source mode allows both.
- Presents one Apple-1 formatted character (bit7 set, upper-case) with a valid/ack handshake to the PIA keyboard port.
- Sits inside the apple1 core between uart/ps2 front-ends and the PIA; replaces the static ps2_select mux.

---
 rtl/kbd_pkg.sv | 27 ++
 rtl/kbd_fifo.sv | 55 +++++
 rtl/kbd_arbiter.sv | 134 +++++++++++++
 tb/tb_kbd_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared encodings and the Apple-1 character formatter for the keyboard arbiter.
// Apple-1 characters are 7-bit upper-case ASCII with bit7 forced high.
package kbd_pkg;

    localparam logic [1:0] SRC_BOTH = 2'b00;
    localparam logic [1:0] SRC_UART = 2'b01;
    localparam logic [1:0] SRC_PS2  = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } kbd_state_e;

    localparam logic [6:0] CASE_OFFSET = 7'h20;
    localparam logic [6:0] LOWER_A     = 7'h61;
    localparam logic [6:0] LOWER_Z     = 7'h7A;

    function automatic logic [7:0] apple1_fmt(input logic [7:0] in);
        logic [6:0] ch;
        ch = in[6:0];
        if (ch >= LOWER_A && ch <= LOWER_Z) begin
            ch = ch - CASE_OFFSET;
        end
        return {1'b1, ch};
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Synchronous FIFO, registered level; data visible the cycle after push.
// A push while full is accepted only when a pop happens in the same cycle.
module kbd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [AW:0]      level_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push, do_pop;

    assign full_o  = (level_q == FULL_LVL);
    assign empty_o = (level_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/kbd_arbiter.sv
// Round-robin merge of buffered UART bytes and the PS/2 holding register into the PIA keyboard port.
// Strobe to kbd_valid is 2 cycles when idle; uart_cts throttles the host as the FIFO fills.
module kbd_arbiter
    import kbd_pkg::*;
#(
    parameter int UART_FIFO_DEPTH = 8,
    parameter int CTS_THRESHOLD   = 6,
    localparam int LW = $clog2(UART_FIFO_DEPTH) + 1
) (
    input  logic          clk25,
    input  logic          rst,
    input  logic [1:0]    src_mode,
    input  logic          uart_valid,
    input  logic [7:0]    uart_data,
    input  logic          ps2_valid,
    input  logic [7:0]    ps2_data,
    input  logic          kbd_ack,
    output logic          kbd_valid,
    output logic [7:0]    kbd_data,
    output logic          uart_cts,
    output logic [7:0]    overrun_cnt,
    output logic [LW-1:0] fifo_level
);

    localparam logic [LW-1:0] CTS_LVL = LW'(CTS_THRESHOLD);

    logic       uart_en, ps2_en, uart_push, ps2_take;
    logic       fifo_full, fifo_empty;
    logic [7:0] fifo_dout;
    logic       uart_rdy, ps2_rdy, grant_uart, grant_ps2;
    logic       uart_ovr, ps2_ovr;
    logic [8:0] ovr_sum;
    logic [7:0] ovr_cnt_d;

    kbd_state_e state_q;
    logic       last_ps2_q, kbd_valid_q, ps2_pend_q, cts_q;
    logic [7:0] kbd_data_q, ps2_byte_q, ovr_cnt_q;

    assign uart_en   = (src_mode != SRC_PS2);
    assign ps2_en    = (src_mode != SRC_UART);
    assign uart_push = uart_valid && uart_en;
    assign ps2_take  = ps2_valid && ps2_en;
    assign uart_rdy  = uart_en && !fifo_empty;
    assign ps2_rdy   = ps2_en && ps2_pend_q;

    // With both sources ready, favour the one that was not served last.
    always_comb begin
        grant_uart = 1'b0;
        grant_ps2  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (uart_rdy && ps2_rdy) begin
                grant_uart = last_ps2_q;
                grant_ps2  = !last_ps2_q;
            end else begin
                grant_uart = uart_rdy;
                grant_ps2  = ps2_rdy;
            end
        end
    end

    kbd_fifo #(
        .DEPTH (UART_FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (clk25),
        .rst_i   (rst),
        .push_i  (uart_push),
        .pop_i   (grant_uart),
        .din_i   (uart_data),
        .dout_o  (fifo_dout),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign uart_ovr  = uart_push && fifo_full && !grant_uart;
    assign ps2_ovr   = ps2_take && ps2_pend_q && !grant_ps2;
    assign ovr_sum   = {1'b0, ovr_cnt_q} + 9'(uart_ovr) + 9'(ps2_ovr);
    assign ovr_cnt_d = ovr_sum[8] ? 8'hFF : ovr_sum[7:0];

    always_ff @(posedge clk25) begin
        if (rst) begin
            ps2_pend_q <= 1'b0;
            ps2_byte_q <= 8'h00;
        end else if (ps2_take) begin
            ps2_pend_q <= 1'b1;
            ps2_byte_q <= ps2_data;
        end else if (grant_ps2) begin
            ps2_pend_q <= 1'b0;
        end
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            kbd_valid_q <= 1'b0;
            kbd_data_q  <= 8'h00;
            last_ps2_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_uart || grant_ps2) begin
                        kbd_data_q  <= apple1_fmt(grant_uart ? fifo_dout : ps2_byte_q);
                        kbd_valid_q <= 1'b1;
                        last_ps2_q  <= grant_ps2;
                        state_q     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (kbd_ack) begin
                        kbd_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            cts_q     <= 1'b0;
            ovr_cnt_q <= 8'h00;
        end else begin
            cts_q     <= (fifo_level < CTS_LVL);
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign kbd_valid   = kbd_valid_q;
    assign kbd_data    = kbd_data_q;
    assign uart_cts    = cts_q;
    assign overrun_cnt = ovr_cnt_q;

endmodule

// File: tb/tb_kbd_arbiter.sv
// Bench for kbd_arbiter: queue-based reference model checked every cycle, plus directed scenarios with literal expectations.
module tb_kbd_arbiter;

    localparam int DEPTH = 8;
    localparam int CTS   = 6;

    logic       clk25 = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] src_mode = 2'b00;
    logic       uart_valid = 1'b0;
    logic [7:0] uart_data = 8'h00;
    logic       ps2_valid = 1'b0;
    logic [7:0] ps2_data = 8'h00;
    logic       kbd_ack = 1'b0;
    logic       kbd_valid;
    logic [7:0] kbd_data;
    logic       uart_cts;
    logic [7:0] overrun_cnt;
    logic [3:0] fifo_level;

    int n_checks = 0;
    int n_fail   = 0;

    always #20 clk25 = ~clk25;

    kbd_arbiter #(
        .UART_FIFO_DEPTH (DEPTH),
        .CTS_THRESHOLD   (CTS)
    ) dut (
        .clk25       (clk25),
        .rst         (rst),
        .src_mode    (src_mode),
        .uart_valid  (uart_valid),
        .uart_data   (uart_data),
        .ps2_valid   (ps2_valid),
        .ps2_data    (ps2_data),
        .kbd_ack     (kbd_ack),
        .kbd_valid   (kbd_valid),
        .kbd_data    (kbd_data),
        .uart_cts    (uart_cts),
        .overrun_cnt (overrun_cnt),
        .fifo_level  (fifo_level)
    );

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int to_apple(input int d);
        int c;
        c = d % 128;
        if (c >= 97 && c <= 122) c = c - 32;
        return c + 128;
    endfunction

    // Reference model: a queue for the UART buffer, a flag/byte for PS/2, a flag for the held character.
    int  m_uq[$];
    bit  m_pend, m_hold, m_last_ps2, m_cts, model_on;
    int  m_pbyte, m_data, m_cnt;
    bit  m_uen, m_pen, m_gu, m_gp, m_cts_nx;
    int  m_inc;

    always @(posedge clk25) begin
        if (rst) begin
            m_uq.delete();
            m_pend = 0; m_pbyte = 0; m_hold = 0; m_data = 0;
            m_last_ps2 = 1; m_cnt = 0; m_cts = 0;
        end else begin
            m_uen = (src_mode != 2'b10);
            m_pen = (src_mode != 2'b01);
            m_gu = 0; m_gp = 0; m_inc = 0;
            m_cts_nx = (m_uq.size() < CTS);
            if (m_hold) begin
                if (kbd_ack) m_hold = 0;
            end else if (m_uen && m_uq.size() > 0 && m_pen && m_pend) begin
                if (m_last_ps2) m_gu = 1; else m_gp = 1;
            end else begin
                m_gu = m_uen && (m_uq.size() > 0);
                m_gp = m_pen && m_pend;
            end
            if (m_gu) begin m_data = to_apple(m_uq.pop_front()); m_hold = 1; m_last_ps2 = 0; end
            if (m_gp) begin m_data = to_apple(m_pbyte); m_hold = 1; m_pend = 0; m_last_ps2 = 1; end
            if (uart_valid && m_uen) begin
                if (m_uq.size() < DEPTH) m_uq.push_back(int'(uart_data));
                else m_inc++;
            end
            if (ps2_valid && m_pen) begin
                if (m_pend) m_inc++;
                m_pend = 1;
                m_pbyte = int'(ps2_data);
            end
            m_cnt = (m_cnt + m_inc > 255) ? 255 : m_cnt + m_inc;
            m_cts = m_cts_nx;
        end
    end

    always @(negedge clk25) begin
        if (model_on) begin
            check("m_kbd_valid", kbd_valid, int'(m_hold));
            if (m_hold) check("m_kbd_data", kbd_data, m_data);
            check("m_uart_cts", uart_cts, int'(m_cts));
            check("m_overrun_cnt", overrun_cnt, m_cnt);
            check("m_fifo_level", fifo_level, m_uq.size());
        end
    end

    task automatic tick();
        @(posedge clk25);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        uart_valid = 1'b0; ps2_valid = 1'b0; kbd_ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic ack_one(input bit strobe, input logic [7:0] pch, output logic [7:0] d);
        int t = 0;
        while (kbd_valid !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        check("wait_kbd_valid", kbd_valid, 1);
        d = kbd_data;
        kbd_ack = 1'b1;
        if (strobe) begin ps2_valid = 1'b1; ps2_data = pch; end
        tick();
        kbd_ack = 1'b0;
        ps2_valid = 1'b0;
        check("ack_gap", kbd_valid, 0);
    endtask

    logic [7:0] got;
    logic [7:0] exp4 [6];
    int u_rate, p_rate, a_rate;

    initial begin
        // 1: reset state and uart_cts rising one cycle after release
        tick();
        model_on = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_kbd_valid", kbd_valid, 0);
        check("rst_overrun", overrun_cnt, 0);
        check("rst_cts", uart_cts, 0);
        check("rst_level", fifo_level, 0);
        tick();
        check("cts_rise", uart_cts, 1);

        // 2: PS/2 lower-case 'a' becomes 0xC1 two cycles later
        src_mode = 2'b00;
        ps2_valid = 1'b1; ps2_data = 8'h61;
        tick();
        ps2_valid = 1'b0;
        check("ps2_lat_n1", kbd_valid, 0);
        tick();
        check("ps2_lat_n2", kbd_valid, 1);
        check("ps2_data", kbd_data, 8'hC1);
        ack_one(1'b0, 8'h00, got);

        // 3: UART burst of eight, then drain in order
        for (int i = 0; i < 8; i++) begin
            uart_valid = 1'b1; uart_data = 8'(8'h31 + i);
            tick();
        end
        uart_valid = 1'b0;
        check("burst_level", fifo_level, 7);
        check("burst_cts", uart_cts, 0);
        check("burst_hold", kbd_data, 8'hB1);
        for (int i = 0; i < 8; i++) begin
            ack_one(1'b0, 8'h00, got);
            check("burst_order", got, 8'hB1 + i);
        end
        check("burst_overrun", overrun_cnt, 0);

        // 4: both sources pending alternate, UART first after reset
        do_reset();
        exp4 = '{8'hC1, 8'hD8, 8'hC2, 8'hD9, 8'hC3, 8'hDA};
        uart_valid = 1'b1; uart_data = "A"; ps2_valid = 1'b1; ps2_data = "x";
        tick();
        ps2_valid = 1'b0; uart_data = "B";
        tick();
        uart_data = "C";
        tick();
        uart_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ack_one(i == 1 || i == 3, (i == 1) ? 8'h79 : 8'h7A, got);
            check("rr_order", got, exp4[i]);
        end

        // 5: overflow drop, disabled PS/2 strobes, push-while-full with pop
        do_reset();
        src_mode = 2'b01;
        for (int i = 0; i < 10; i++) begin
            uart_valid = 1'b1; uart_data = 8'(8'h41 + i);
            tick();
        end
        uart_valid = 1'b0;
        check("full_level", fifo_level, 8);
        check("full_overrun", overrun_cnt, 1);
        check("full_hold", kbd_data, 8'hC1);
        for (int i = 0; i < 2; i++) begin
            ps2_valid = 1'b1; ps2_data = 8'h70;
            tick();
        end
        ps2_valid = 1'b0;
        check("ps2_disabled_overrun", overrun_cnt, 1);
        ack_one(1'b0, 8'h00, got);
        uart_valid = 1'b1; uart_data = "Z";
        tick();
        uart_valid = 1'b0;
        check("push_pop_full_level", fifo_level, 8);
        check("push_pop_full_overrun", overrun_cnt, 1);
        src_mode = 2'b00;
        for (int i = 0; i < 9; i++) begin
            ack_one(1'b0, 8'h00, got);
            check("drain_order", got, (i < 8) ? 8'hC2 + i : 8'hDA);
        end

        // 6: reset during HOLD flushes everything
        do_reset();
        for (int i = 0; i < 5; i++) begin
            uart_valid = 1'b1; uart_data = 8'(8'h61 + i);
            tick();
        end
        uart_valid = 1'b0;
        check("pre_rst_valid", kbd_valid, 1);
        check("pre_rst_level", fifo_level, 4);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", kbd_valid, 0);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_overrun", overrun_cnt, 0);
        rst = 1'b0;
        repeat (5) tick();
        check("post_rst_valid", kbd_valid, 0);

        // Randomized traffic; the middle segment floods to saturate the overrun counter
        for (int seg = 0; seg < 3; seg++) begin
            u_rate = (seg == 1) ? 70 : (seg == 0 ? 30 : 20);
            p_rate = (seg == 1) ? 70 : 20;
            a_rate = (seg == 1) ? 3 : (seg == 0 ? 40 : 60);
            src_mode = 2'b00;
            for (int c = 0; c < 800; c++) begin
                if (seg != 1 && $urandom_range(0, 99) < 3) src_mode = 2'($urandom_range(0, 3));
                uart_valid = ($urandom_range(0, 99) < u_rate);
                uart_data  = 8'($urandom);
                ps2_valid  = ($urandom_range(0, 99) < p_rate);
                ps2_data   = 8'($urandom);
                kbd_ack    = (kbd_valid && $urandom_range(0, 99) < a_rate) || ($urandom_range(0, 99) < 2);
                tick();
            end
            uart_valid = 1'b0; ps2_valid = 1'b0; kbd_ack = 1'b0;
            if (seg == 1) check("overrun_saturated", overrun_cnt, 255);
        end
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
